// File: rtl/dft_wb_stream_bridge.sv
// -----------------------------------------------------------------------------
// dft_wb_stream_bridge
//
// Wishbone slave that bridges host accesses to the DFT datapath core.
//   - Host writes to DATA_IN are buffered in an input FIFO and streamed to the
//     core over smp_valid/smp_ready.
//   - Core results arriving on res_valid/res_ready are buffered in an output
//     FIFO and read back (and popped) through DATA_OUT.
//   - STATUS reports FIFO levels and flags; CTRL holds flush and irq_en.
//
// Register map (wb_adr_i[3:2]):
//   0 DATA_IN  (W)  push input FIFO
//   1 DATA_OUT (R)  read + pop output FIFO head
//   2 STATUS   (R)  [31:24] in_count, [23:16] out_count,
//                   [3] out_full, [2] out_empty, [1] in_full, [0] in_empty
//   3 CTRL     (RW) bit0 flush (write-1, self-clearing, reads 0), bit1 irq_en
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   wb_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i   Wishbone slave inputs
//   wb_dat_o/ack_o/err_o            Wishbone slave response (registered)
//   smp_valid/smp_data/smp_ready    sample stream to the core
//   res_valid/res_data/res_ready    result stream from the core
//   irq                             level interrupt: results pending & irq_en
// -----------------------------------------------------------------------------
module dft_wb_stream_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int IN_DEPTH   = 16,
  parameter int OUT_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  smp_valid,
  output logic [DATA_WIDTH-1:0] smp_data,
  input  logic                  smp_ready,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_ready,
  output logic                  irq
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int ICW = IAW + 1;
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int OCW = OAW + 1;

  localparam logic [1:0] REG_DATA_IN  = 2'd0;
  localparam logic [1:0] REG_DATA_OUT = 2'd1;
  localparam logic [1:0] REG_STATUS   = 2'd2;
  localparam logic [1:0] REG_CTRL     = 2'd3;

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t r_state;
  logic   r_irq_en;

  // Input FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] r_in_mem [IN_DEPTH];
  logic [IAW-1:0]        r_in_wr;
  logic [IAW-1:0]        r_in_rd;
  logic [ICW-1:0]        r_in_cnt;

  // Output FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] r_out_mem [OUT_DEPTH];
  logic [OAW-1:0]        r_out_wr;
  logic [OAW-1:0]        r_out_rd;
  logic [OCW-1:0]        r_out_cnt;

  logic        w_in_empty, w_in_full, w_out_empty, w_out_full;
  logic        w_in_pop, w_out_push;
  logic        w_req;
  logic        w_err;
  logic [31:0] w_rdata;
  logic        w_in_push, w_out_pop, w_ctrl_wr, w_flush;
  logic        w_unused;

  // Only adr[3:2] is decoded; the rest of the address is intentionally ignored.
  assign w_unused = ^{wb_adr_i[31:4], wb_adr_i[1:0]};

  assign w_in_empty  = (r_in_cnt == '0);
  assign w_in_full   = (r_in_cnt == ICW'(IN_DEPTH));
  assign w_out_empty = (r_out_cnt == '0);
  assign w_out_full  = (r_out_cnt == OCW'(OUT_DEPTH));

  assign smp_valid  = !w_in_empty;
  assign smp_data   = r_in_mem[r_in_rd];
  assign res_ready  = !w_out_full;
  assign irq        = r_irq_en & !w_out_empty;

  assign w_in_pop   = smp_valid & smp_ready;
  assign w_out_push = res_valid & res_ready;

  // A strobe is only sampled in IDLE; a strobe held through RESP is ignored.
  assign w_req = (r_state == S_IDLE) & wb_cyc_i & wb_stb_i;

  // Access decode: decides ack vs err, read data and side effects.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    w_err     = 1'b0;
    w_rdata   = '0;
    w_in_push = 1'b0;
    w_out_pop = 1'b0;
    w_ctrl_wr = 1'b0;
    w_flush   = 1'b0;
    if (w_req) begin
      unique case (wb_adr_i[3:2])
        REG_DATA_IN: begin
          // A full FIFO still accepts the write if the core drains a word
          // on the same edge.
          if (!wb_we_i || (wb_sel_i != 4'hF) || (w_in_full && !w_in_pop)) begin
            w_err = 1'b1;
          end else begin
            w_in_push = 1'b1;
          end
        end
        REG_DATA_OUT: begin
          if (wb_we_i || w_out_empty) begin
            w_err = 1'b1;
          end else begin
            w_out_pop = 1'b1;
            w_rdata   = r_out_mem[r_out_rd];
          end
        end
        REG_STATUS: begin
          if (wb_we_i) begin
            w_err = 1'b1;
          end else begin
            w_rdata[31:24] = 8'(r_in_cnt);
            w_rdata[23:16] = 8'(r_out_cnt);
            w_rdata[3:0]   = {w_out_full, w_out_empty, w_in_full, w_in_empty};
          end
        end
        REG_CTRL: begin
          if (wb_we_i) begin
            w_ctrl_wr = 1'b1;
            w_flush   = wb_dat_i[0];
          end else begin
            w_rdata[1] = r_irq_en;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus FSM: response registered on the strobe edge, held for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state  <= S_IDLE;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_state  <= S_RESP;
            wb_ack_o <= !w_err;
            wb_err_o <= w_err;
            wb_dat_o <= w_rdata;
          end
        end
        S_RESP: begin
          r_state  <= S_IDLE;
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          wb_dat_o <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_en <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_irq_en <= wb_dat_i[1];
    end
  end

  // NOTE: FIFO storage has no reset; validity is tracked by the pointers and
  // counts alone, which keeps the arrays as plain RAM.
  always_ff @(posedge clk) begin
    if (w_in_push) r_in_mem[r_in_wr] <= wb_dat_i;
    if (w_out_push) r_out_mem[r_out_wr] <= res_data;
  end

  // Input FIFO pointers/count; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_wr  <= '0;
      r_in_rd  <= '0;
      r_in_cnt <= '0;
    end else if (w_flush) begin
      r_in_wr  <= '0;
      r_in_rd  <= '0;
      r_in_cnt <= '0;
    end else begin
      if (w_in_push) r_in_wr <= r_in_wr + IAW'(1);
      if (w_in_pop)  r_in_rd <= r_in_rd + IAW'(1);
      unique case ({w_in_push, w_in_pop})
        2'b10:   r_in_cnt <= r_in_cnt + ICW'(1);
        2'b01:   r_in_cnt <= r_in_cnt - ICW'(1);
        default: ;
      endcase
    end
  end

  // Output FIFO pointers/count; same flush priority as the input side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_wr  <= '0;
      r_out_rd  <= '0;
      r_out_cnt <= '0;
    end else if (w_flush) begin
      r_out_wr  <= '0;
      r_out_rd  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_out_push) r_out_wr <= r_out_wr + OAW'(1);
      if (w_out_pop)  r_out_rd <= r_out_rd + OAW'(1);
      unique case ({w_out_push, w_out_pop})
        2'b10:   r_out_cnt <= r_out_cnt + OCW'(1);
        2'b01:   r_out_cnt <= r_out_cnt - OCW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dft_wb_stream_bridge.sv
// -----------------------------------------------------------------------------
// tb_dft_wb_stream_bridge
//
// Self-checking bench for dft_wb_stream_bridge. A register-access table covers
// reset state and error decoding; hand-written sequences cover streaming,
// full/empty boundaries, irq, flush, held strobes and reset during RESP.
// Expected samples/results live in scoreboard queues filled as stimulus is
// driven and drained as the DUT produces output.
// -----------------------------------------------------------------------------
module tb_dft_wb_stream_bridge;

  logic        clk;
  logic        rst_n;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        smp_valid;
  logic [31:0] smp_data;
  logic        smp_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;
  logic        irq;

  dft_wb_stream_bridge #(
    .DATA_WIDTH(32),
    .IN_DEPTH  (16),
    .OUT_DEPTH (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .smp_valid(smp_valid),
    .smp_data (smp_data),
    .smp_ready(smp_ready),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_ready(res_ready),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_samples = 0;

  logic [31:0] in_q[$];
  logic [31:0] out_q[$];

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // One Wishbone access. Optionally pulses smp_ready and/or res_valid on the
  // edge where the strobe is sampled. Returns with the FSM back in IDLE.
  task automatic bus(input string name, input logic we, input logic [1:0] a,
                     input logic [31:0] d, input logic [3:0] sel,
                     input logic exp_err, input logic [31:0] exp_dat,
                     input logic pulse_rdy, input logic pulse_res);
    logic        got;
    logic        ack, err;
    logic [31:0] q;
    got = 1'b0; ack = 1'b0; err = 1'b0; q = '0;
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = {28'h0, a, 2'b00};
    wb_dat_i = d;
    wb_sel_i = sel;
    if (pulse_rdy) smp_ready = 1'b1;
    if (pulse_res) begin res_valid = 1'b1; res_data = 32'hFEED_0000; end
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (pulse_rdy) smp_ready = 1'b0;
      if (pulse_res) res_valid = 1'b0;
      if (wb_ack_o || wb_err_o) begin
        got = 1'b1; ack = wb_ack_o; err = wb_err_o; q = wb_dat_o;
      end
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    check({name, " ack"}, 32'(ack), 32'(!exp_err));
    check({name, " err"}, 32'(err), 32'(exp_err));
    check({name, " dat"}, q, exp_dat);
    if (we && a == 2'd0 && !exp_err) in_q.push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic drive_result(input logic [31:0] d);
    @(negedge clk);
    res_valid = 1'b1;
    res_data  = d;
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  function automatic logic [31:0] next_out();
    if (out_q.size() == 0) return 32'hBAD0_BAD0;
    return out_q.pop_front();
  endfunction

  // Stream monitor: sampled mid-cycle, i.e. what the next rising edge sees.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (rst_n) begin
        if (smp_valid && smp_ready) begin
          n_samples++;
          if (in_q.size() == 0) check("sample unexpected", 32'(smp_valid), 32'h0);
          else check("sample data", smp_data, in_q.pop_front());
        end
        if (res_valid && res_ready) out_q.push_back(res_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    vecs[0]  = '{"rst status",      1'b0, 2'd2, 32'h0,         4'hF, 1'b0, 32'h0000_0005};
    vecs[1]  = '{"rst ctrl",        1'b0, 2'd3, 32'h0,         4'hF, 1'b0, 32'h0};
    vecs[2]  = '{"rd data_in",      1'b0, 2'd0, 32'h0,         4'hF, 1'b1, 32'h0};
    vecs[3]  = '{"wr status",       1'b1, 2'd2, 32'h1111_1111, 4'hF, 1'b1, 32'h0};
    vecs[4]  = '{"wr data_out",     1'b1, 2'd1, 32'h2222_2222, 4'hF, 1'b1, 32'h0};
    vecs[5]  = '{"rd data_out mt",  1'b0, 2'd1, 32'h0,         4'hF, 1'b1, 32'h0};
    vecs[6]  = '{"wr data_in sel",  1'b1, 2'd0, 32'h3333_3333, 4'h3, 1'b1, 32'h0};
    vecs[7]  = '{"wr ctrl junk",    1'b1, 2'd3, 32'hFFFF_FFFC, 4'hF, 1'b0, 32'h0};
    vecs[8]  = '{"rd ctrl junk",    1'b0, 2'd3, 32'h0,         4'hF, 1'b0, 32'h0};
    vecs[9]  = '{"wr ctrl ien",     1'b1, 2'd3, 32'h0000_0002, 4'hF, 1'b0, 32'h0};
    vecs[10] = '{"rd ctrl ien",     1'b0, 2'd3, 32'h0,         4'hF, 1'b0, 32'h0000_0002};
    vecs[11] = '{"wr ctrl off",     1'b1, 2'd3, 32'h0,         4'hF, 1'b0, 32'h0};
    vecs[12] = '{"status no fx",    1'b0, 2'd2, 32'h0,         4'hF, 1'b0, 32'h0000_0005};

    rst_n = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    smp_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset ack", 32'(wb_ack_o), 32'h0);
    check("reset err", 32'(wb_err_o), 32'h0);
    check("reset dat", wb_dat_o, 32'h0);
    check("reset smp_valid", 32'(smp_valid), 32'h0);
    check("reset res_ready", 32'(res_ready), 32'h1);
    check("reset irq", 32'(irq), 32'h0);

    foreach (vecs[i])
      bus(vecs[i].name, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
          vecs[i].exp_err, vecs[i].exp_dat, 1'b0, 1'b0);

    // Three buffered samples, then released on consecutive cycles
    for (int k = 1; k <= 3; k++)
      bus("A wr", 1'b1, 2'd0, 32'hA5A5_0000 + 32'(k), 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
    bus("A status", 1'b0, 2'd2, 32'h0, 4'hF, 1'b0, 32'h0300_0004, 1'b0, 1'b0);
    base = n_samples;
    @(negedge clk);
    smp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("A smp_valid", 32'(smp_valid), 32'h1);
      @(negedge clk);
    end
    #1;
    check("A smp_valid after", 32'(smp_valid), 32'h0);
    check("A sample count", 32'(n_samples - base), 32'd3);
    smp_ready = 1'b0;

    // Input FIFO full boundary
    for (int k = 0; k < 16; k++)
      bus("B fill", 1'b1, 2'd0, 32'hB000_0000 + 32'(k), 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
    bus("B overflow", 1'b1, 2'd0, 32'hB0FF_FFFF, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);
    bus("B status full", 1'b0, 2'd2, 32'h0, 4'hF, 1'b0, 32'h1000_0006, 1'b0, 1'b0);
    bus("B wr full+pop", 1'b1, 2'd0, 32'hB000_0010, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0);
    bus("B status still", 1'b0, 2'd2, 32'h0, 4'hF, 1'b0, 32'h1000_0006, 1'b0, 1'b0);
    base = n_samples;
    @(negedge clk);
    smp_ready = 1'b1;
    repeat (18) @(negedge clk);
    smp_ready = 1'b0;
    #1;
    check("B drain count", 32'(n_samples - base), 32'd16);
    check("B drained valid", 32'(smp_valid), 32'h0);

    // irq and DATA_OUT read/pop
    bus("C ctrl ien", 1'b1, 2'd3, 32'h0000_0002, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
    check("C irq idle", 32'(irq), 32'h0);
    drive_result(32'h1234_5678);
    check("C irq set", 32'(irq), 32'h1);
    bus("C rd result", 1'b0, 2'd1, 32'h0, 4'hF, 1'b0, next_out(), 1'b0, 1'b0);
    check("C irq clear", 32'(irq), 32'h0);
    bus("C rd empty", 1'b0, 2'd1, 32'h0, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);

    // Output FIFO full, then flush with both FIFOs occupied
    for (int k = 0; k < 16; k++) drive_result(32'hC000_0000 + 32'(k));
    check("D res_ready full", 32'(res_ready), 32'h0);
    bus("D status ofull", 1'b0, 2'd2, 32'h0, 4'hF, 1'b0, 32'h0010_0009, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      bus("D in wr", 1'b1, 2'd0, 32'hD000_0000 + 32'(k), 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
    bus("D status both", 1'b0, 2'd2, 32'h0, 4'hF, 1'b0, 32'h0510_0008, 1'b0, 1'b0);
    bus("D flush", 1'b1, 2'd3, 32'h0000_0001, 4'hF, 1'b0, 32'h0, 1'b1, 1'b1);
    in_q.delete();
    out_q.delete();
    check("D smp_valid", 32'(smp_valid), 32'h0);
    check("D res_ready", 32'(res_ready), 32'h1);
    check("D irq", 32'(irq), 32'h0);
    bus("D status flushed", 1'b0, 2'd2, 32'h0, 4'hF, 1'b0, 32'h0000_0005, 1'b0, 1'b0);

    // Result ordering after the flush
    drive_result(32'hE000_0001);
    drive_result(32'hE000_0002);
    drive_result(32'hE000_0003);
    for (int k = 0; k < 3; k++)
      bus("E rd order", 1'b0, 2'd1, 32'h0, 4'hF, 1'b0, next_out(), 1'b0, 1'b0);

    // Strobe held for four cycles: only two accesses are taken
    begin
      logic [3:0] acks;
      @(negedge clk);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = 32'h0; wb_dat_i = 32'hF00D_0001; wb_sel_i = 4'hF;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        acks[i] = wb_ack_o;
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      check("F ack pattern", 32'(acks), 32'h5);
      in_q.push_back(32'hF00D_0001);
      in_q.push_back(32'hF00D_0001);
    end
    bus("F status", 1'b0, 2'd2, 32'h0, 4'hF, 1'b0, 32'h0200_0004, 1'b0, 1'b0);

    // Reset asserted while a response is on the bus
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h0; wb_dat_i = 32'hF00D_0002; wb_sel_i = 4'hF;
    @(posedge clk); #1;
    check("G ack in resp", 32'(wb_ack_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("G ack dropped", 32'(wb_ack_o), 32'h0);
    check("G smp_valid", 32'(smp_valid), 32'h0);
    check("G res_ready", 32'(res_ready), 32'h1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    in_q.delete();
    out_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("G no late ack", 32'(wb_ack_o), 32'h0);
    bus("G status", 1'b0, 2'd2, 32'h0, 4'hF, 1'b0, 32'h0000_0005, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
